io_port_bank: RTL

- Parametrised memory-mapped I/O bank for the computer, replacing the fixed 16×8-bit port_in/port_out set.
- Provides NPORTS registered output ports and NPORTS synchronised input ports, each WIDTH bits wide.
- Adds per-port input change detection with interrupt pending/enable bits and a single interrupt line.
- Sits on the CPU data bus next to data memory. Decodes the address and returns registered read data.

---
 rtl/io_port_bank.sv | 123 ++++++++++++
 1 files changed

// File: rtl/io_port_bank.sv
// io_port_bank
//   Memory-mapped I/O bank on the CPU data bus. Provides NPORTS registered
//   output ports, NPORTS synchronised input ports, and per-port input change
//   detection with pending/enable bits folded into a single interrupt line.
//
//   Address map (k < NPORTS):
//     OUT_BASE  + k : output register, read/write
//     IN_BASE   + k : synchronised input, read-only
//     CTRL_BASE + k : bit0 pending (write 1 to clear), bit1 enable
//   Every other address reads 0 and ignores writes.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high
//   address   bus address
//   data_in   write data
//   write     one-cycle write strobe
//   data_out  registered read data, one cycle after the address
//   port_in   input ports, port k at [k*WIDTH +: WIDTH], asynchronous to clk
//   port_out  registered output ports, same packing as port_in
//   irq       registered OR of (pending & enable)
module io_port_bank #(
    parameter int                WIDTH     = 8,
    parameter int                NPORTS    = 16,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] OUT_BASE  = 8'hE0,
    parameter logic [ADDR_W-1:0] IN_BASE   = 8'hF0,
    parameter logic [ADDR_W-1:0] CTRL_BASE = 8'hC0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       address,
    input  logic [WIDTH-1:0]        data_in,
    input  logic                    write,
    output logic [WIDTH-1:0]        data_out,
    input  logic [NPORTS*WIDTH-1:0] port_in,
    output logic [NPORTS*WIDTH-1:0] port_out,
    output logic                    irq
);

    logic [NPORTS-1:0][WIDTH-1:0] out_reg;
    logic [NPORTS-1:0][WIDTH-1:0] sync1;
    logic [NPORTS-1:0][WIDTH-1:0] sync2;
    logic [NPORTS-1:0][WIDTH-1:0] prev;
    logic [NPORTS-1:0]            pending;
    logic [NPORTS-1:0]            enable;
    logic [1:0]                   arm_cnt;
    logic                         armed;

    logic [NPORTS-1:0]            out_sel;
    logic [NPORTS-1:0]            in_sel;
    logic [NPORTS-1:0]            ctrl_sel;
    logic [WIDTH-1:0]             rd_data;
    logic [WIDTH-1:0]             ctrl_word;

    assign port_out = out_reg;

    // Detection stays off for the first edges after reset so that whatever
    // sits on the pins at reset release never raises a spurious interrupt.
    assign armed = (arm_cnt == 2'd3);

    always_comb begin
        out_sel  = '0;
        in_sel   = '0;
        ctrl_sel = '0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            out_sel[k]  = (address == ADDR_W'(OUT_BASE  + k));
            in_sel[k]   = (address == ADDR_W'(IN_BASE   + k));
            ctrl_sel[k] = (address == ADDR_W'(CTRL_BASE + k));
        end
    end

    always_comb begin
        rd_data   = '0;
        ctrl_word = '0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            if (out_sel[k]) rd_data = out_reg[k];
            if (in_sel[k])  rd_data = sync2[k];
            if (ctrl_sel[k]) begin
                ctrl_word    = '0;
                ctrl_word[0] = pending[k];
                ctrl_word[1] = enable[k];
                rd_data      = ctrl_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg  <= '0;
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            pending  <= '0;
            enable   <= '0;
            arm_cnt  <= '0;
            data_out <= '0;
            irq      <= 1'b0;
        end else begin
            sync1 <= port_in;
            sync2 <= sync1;
            prev  <= sync2;

            if (!armed) arm_cnt <= arm_cnt + 2'd1;

            // Read data comes from pre-edge state, so a read during a write
            // to the same register returns the old value.
            data_out <= rd_data;
            irq      <= |(pending & enable);

            for (int unsigned k = 0; k < NPORTS; k++) begin
                if (write && out_sel[k]) out_reg[k] <= data_in;
                if (write && ctrl_sel[k]) enable[k] <= data_in[1];
                // A detected change on the same edge as a clear keeps it pending.
                if (armed && (sync2[k] != prev[k]))
                    pending[k] <= 1'b1;
                else if (write && ctrl_sel[k] && data_in[0])
                    pending[k] <= 1'b0;
            end
        end
    end

endmodule
